cp0_ctrl: RTL and testbench
===========================

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port A, input, 5 bits: CP0 register index for the mfc0 read and the mtc0 write.
REQ-005 SHALL have port din, input, 32 bits: mtc0 write data.
REQ-006 SHALL have port we, input, 1 bit: mtc0 write enable.
REQ-007 SHALL have port pc_M, input, 32 bits: PC of the instruction in the M stage.
REQ-008 SHALL have port excCode_M, input, 5 bits: pending exception code of the M stage instruction (0 = none).
REQ-009 SHALL have port bd_M, input, 1 bit: M stage instruction sits in a delay slot.
REQ-010 SHALL have port HWInt, input, 6 bits: external hardware interrupt lines.
REQ-011 SHALL have port EXLClr, input, 1 bit: eret committing.
REQ-012 SHALL have port vaddr_M, input, 32 bits: faulting data address; present only when CP0_BADVADDR_EN is defined.
REQ-013 SHALL have port req, output, 1 bit: flush the pipeline and redirect the PC to 0x4180.
REQ-014 SHALL have port EPC, output, 32 bits: current EPC register value, used as the eret target.
REQ-015 SHALL have port dout, output, 32 bits: combinational mfc0 read data.

Function
REQ-016 SHALL implement these registers:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC (14).
- PRId (15): constant 0x0000_2021.
REQ-017 SHALL drive IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL, combinationally in the same cycle.
REQ-018 SHALL drive ExcReq = (excCode_M != 0) & ~SR.EXL, combinationally; req = IntReq | ExcReq.
REQ-019 SHALL, at the edge where req=1, perform these updates:
- EXL <= 1.
- Cause.ExcCode <= (IntReq ? 0 : excCode_M); interrupt wins when both are pending.
- Cause.BD <= bd_M.
- EPC <= (bd_M ? pc_M-4 : pc_M) with bits[1:0] forced to 0.
REQ-020 SHALL load Cause.IP <= HWInt at every edge, independent of req.
REQ-021 SHALL, on an mtc0 (we=1 and req=0), write only the writable fields:
- SR: IM, EXL, IE.
- EPC: din with bits[1:0] forced to 0.
- Writes to Cause, PRId and unknown indices are ignored.
REQ-022 SHALL drop an mtc0 write that coincides with req=1.
REQ-023 SHALL clear EXL on an edge where EXLClr=1 and req=0; when both are 1, req takes priority.
REQ-024 SHALL make dout = register(A) combinationally, with 0 for unimplemented indices; a write becomes visible from the cycle after its edge.
REQ-025 SHALL hold all state with req=0 while EXL=1, so nested exceptions are masked.

Reset
REQ-026 SHALL, on reset=1 at an edge, clear SR, Cause and EPC (and BadVAddr) to 0; req=0 in the following cycle.
REQ-027 SHALL give reset priority over req, mtc0 and EXLClr in the same cycle.

Configuration
REQ-028 SHALL, with CP0_BADVADDR_EN defined, add BadVAddr (8):
- loads vaddr_M at a req edge when excCode_M is 4 or 5 and IntReq=0;
- read-only.
REQ-029 SHALL, without CP0_BADVADDR_EN, omit the vaddr_M port and read index 8 as 0.

Structure
REQ-030 SHALL place in shared package cp0_pkg:
- register indices;
- SR/Cause field bit positions;
- exception codes Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
- handler vector 0x4180;
- PRId constant.
REQ-031 SHALL be a single module with no sub-module.

Verification
REQ-032 SHALL cover: reset, then A=12 -> dout=0, req=0.
REQ-033 SHALL cover: mtc0 SR=0x0000_FC01, then HWInt=6'b000100, pc_M=0x3020 -> req=1 that cycle; next cycle SR=0x0000_FC03, Cause=0x0000_1000, EPC=0x3020.
REQ-034 SHALL cover: excCode_M=12, pc_M=0x3010, bd_M=1, EXL=0 -> req=1; next cycle Cause=0x8000_0030, EPC=0x300C.
REQ-035 SHALL cover: EXL=1, excCode_M=4 -> req=0 and no register change; then EXLClr=1 -> SR.EXL=0 next cycle.
REQ-036 SHALL cover: mtc0 EPC=0x3005 with req=1 -> EPC unchanged; retry with req=0 -> EPC reads 0x3004.
REQ-037 SHALL cover: with CP0_BADVADDR_EN, excCode_M=5, vaddr_M=0x2FFE -> A=8 reads 0x2FFE; without the macro, A=8 reads 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions, exception codes, vectors.
package cp0_pkg;

    localparam logic [4:0] IDX_BADVADDR = 5'd8;
    localparam logic [4:0] IDX_SR       = 5'd12;
    localparam logic [4:0] IDX_CAUSE    = 5'd13;
    localparam logic [4:0] IDX_EPC      = 5'd14;
    localparam logic [4:0] IDX_PRID     = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int SR_IM_HI      = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD_BIT  = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE     = 32'h0000_2021;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Bundle of pipeline <-> CP0 signals; master is the pipeline side, slave is the CP0 side.
// vaddr_M is only consumed by cp0_ctrl when CP0_BADVADDR_EN is defined.
interface cp0_ctrl_if;
    logic [4:0]  A;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc_M;
    logic [4:0]  excCode_M;
    logic        bd_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] vaddr_M;
    logic        req;
    logic [31:0] EPC;
    logic [31:0] dout;

    modport master (
        output A, din, we, pc_M, excCode_M, bd_M, HWInt, EXLClr, vaddr_M,
        input  req, EPC, dout
    );

    modport slave (
        input  A, din, we, pc_M, excCode_M, bd_M, HWInt, EXLClr, vaddr_M,
        output req, EPC, dout
    );
endinterface

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId and exception entry/return.
// Optional BadVAddr register (index 8) is built when CP0_BADVADDR_EN is defined.
module cp0_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc_M,
    input  logic [4:0]  excCode_M,
    input  logic        bd_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] vaddr_M,
`endif
    output logic        req,
    output logic [31:0] EPC,
    output logic [31:0] dout
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;
`endif

    logic int_req;
    logic exc_req;

    assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (excCode_M != 5'd0) & ~sr_exl_q;
    assign req     = int_req | exc_req;
    assign EPC     = epc_q;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        cause_ip_d  = HWInt;
        epc_d       = epc_q;
`ifdef CP0_BADVADDR_EN
        badvaddr_d  = badvaddr_q;
`endif
        if (req) begin
            // Exception entry: a coinciding mtc0 or eret is dropped.
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : excCode_M;
            cause_bd_d  = bd_M;
            epc_d       = word_align(bd_M ? (pc_M - 32'd4) : pc_M);
`ifdef CP0_BADVADDR_EN
            if (!int_req && (excCode_M == EXC_ADEL || excCode_M == EXC_ADES)) begin
                badvaddr_d = vaddr_M;
            end
`endif
        end else begin
            if (we) begin
                case (A)
                    IDX_SR: begin
                        sr_im_d  = din[SR_IM_HI:SR_IM_LO];
                        sr_exl_d = din[SR_EXL_BIT];
                        sr_ie_d  = din[SR_IE_BIT];
                    end
                    IDX_EPC: epc_d = word_align(din);
                    default: ;
                endcase
            end
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q  <= '0;
`endif
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
`ifdef CP0_BADVADDR_EN
            badvaddr_q  <= badvaddr_d;
`endif
        end
    end

    always_comb begin
        dout = '0;
        case (A)
            IDX_SR:    dout = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
            IDX_CAUSE: dout = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
            IDX_EPC:   dout = epc_q;
            IDX_PRID:  dout = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
            IDX_BADVADDR: dout = badvaddr_q;
`endif
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios, then random traffic against a word-level model.
module tb_cp0_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cp0_ctrl_if bus();

    cp0_ctrl dut (
        .clk       (clk),
        .reset     (rst),
        .A         (bus.A),
        .din       (bus.din),
        .we        (bus.we),
        .pc_M      (bus.pc_M),
        .excCode_M (bus.excCode_M),
        .bd_M      (bus.bd_M),
        .HWInt     (bus.HWInt),
        .EXLClr    (bus.EXLClr),
`ifdef CP0_BADVADDR_EN
        .vaddr_M   (bus.vaddr_M),
`endif
        .req       (bus.req),
        .EPC       (bus.EPC),
        .dout      (bus.dout)
    );

    // Reference model: whole architectural register words, updated by the documented rules.
    logic [31:0] m_sr = '0;
    logic [31:0] m_cause = '0;
    logic [31:0] m_epc = '0;
    logic [31:0] m_bva = '0;
    logic        m_ir, m_take;

    function automatic logic m_int();
        return (|(bus.HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((bus.excCode_M != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_bva;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h0000_2021;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_sr = '0; m_cause = '0; m_epc = '0; m_bva = '0;
        end else begin
            m_ir   = m_int();
            m_take = m_req();
            if (m_take) begin
                m_sr[1]      = 1'b1;
                m_cause[31]  = bus.bd_M;
                m_cause[6:2] = m_ir ? 5'd0 : bus.excCode_M;
                m_epc        = (bus.bd_M ? bus.pc_M - 32'd4 : bus.pc_M) & 32'hFFFF_FFFC;
                if (!m_ir && (bus.excCode_M == 5'd4 || bus.excCode_M == 5'd5))
                    m_bva = bus.vaddr_M;
            end else begin
                if (bus.we && bus.A == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
                if (bus.we && bus.A == 5'd14) m_epc = bus.din & 32'hFFFF_FFFC;
                if (bus.EXLClr) m_sr[1] = 1'b0;
            end
            m_cause[15:10] = bus.HWInt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] exc, input logic [31:0] pc, input logic bd,
                         input logic [5:0] hw, input logic clr);
        bus.we = w; bus.A = a; bus.din = d; bus.excCode_M = exc;
        bus.pc_M = pc; bus.bd_M = bd; bus.HWInt = hw; bus.EXLClr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.we = 1'b0; bus.EXLClr = 1'b0; bus.excCode_M = 5'd0; bus.bd_M = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.A = a;
        #1;
        check(tag, bus.dout, exp);
    endtask

    logic [4:0] idx_tbl [6] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    logic [4:0] exc_tbl [7] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    logic [31:0] bva_exp;

    initial begin
        drive(0, 5'd0, 32'h0, 5'd0, 32'h0, 0, 6'h0, 0);
        bus.vaddr_M = 32'h0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_req", {31'b0, bus.req}, 32'h0);
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, 32'h0000_2021, "prid");
        check("rst_epc_port", bus.EPC, 32'h0);

        // Interrupt entry
        drive(1, 5'd12, 32'h0000_FC01, 5'd0, 32'h3020, 0, 6'h0, 0);
        #1 check("mtc0_sr_req", {31'b0, bus.req}, 32'h0);
        tick();
        rd(5'd12, 32'h0000_FC01, "sr_written");
        drive(0, 5'd12, 32'h0, 5'd0, 32'h3020, 0, 6'b000100, 0);
        #1 check("int_req", {31'b0, bus.req}, 32'h1);
        tick();
        rd(5'd12, 32'h0000_FC03, "int_sr");
        rd(5'd13, 32'h0000_1000, "int_cause");
        rd(5'd14, 32'h0000_3020, "int_epc");
        check("int_epc_port", bus.EPC, 32'h0000_3020);
        check("int_masked_req", {31'b0, bus.req}, 32'h0);
        drive(0, 5'd12, 32'h0, 5'd0, 32'h3020, 0, 6'h0, 1);
        tick();
        rd(5'd12, 32'h0000_FC01, "eret_sr");
        drive(1, 5'd12, 32'h0, 5'd0, 32'h3020, 0, 6'h0, 0);
        tick();
        rd(5'd12, 32'h0, "sr_cleared");

        // Overflow in a delay slot
        drive(0, 5'd13, 32'h0, 5'd12, 32'h3010, 1, 6'h0, 0);
        #1 check("ov_req", {31'b0, bus.req}, 32'h1);
        tick();
        rd(5'd13, 32'h8000_0030, "ov_cause");
        rd(5'd14, 32'h0000_300C, "ov_epc");
        rd(5'd12, 32'h0000_0002, "ov_sr");

        // Nested exception masked while EXL=1
        drive(0, 5'd13, 32'h0, 5'd4, 32'h3050, 0, 6'h0, 0);
        #1 check("nested_req", {31'b0, bus.req}, 32'h0);
        tick();
        rd(5'd13, 32'h8000_0030, "nested_cause");
        rd(5'd14, 32'h0000_300C, "nested_epc");
        rd(5'd12, 32'h0000_0002, "nested_sr");
        drive(0, 5'd12, 32'h0, 5'd0, 32'h3050, 0, 6'h0, 1);
        tick();
        rd(5'd12, 32'h0, "exlclr_sr");

        // mtc0 EPC colliding with an exception is dropped, then retried
        drive(1, 5'd14, 32'h3005, 5'd10, 32'h3040, 0, 6'h0, 0);
        #1 check("epcw_req", {31'b0, bus.req}, 32'h1);
        tick();
        rd(5'd14, 32'h0000_3040, "epcw_dropped");
        rd(5'd13, 32'h0000_0028, "ri_cause");
        drive(0, 5'd12, 32'h0, 5'd0, 32'h3040, 0, 6'h0, 1);
        tick();
        drive(1, 5'd14, 32'h3005, 5'd0, 32'h3040, 0, 6'h0, 0);
        #1 check("epcw_retry_req", {31'b0, bus.req}, 32'h0);
        tick();
        rd(5'd14, 32'h0000_3004, "epcw_retry");

        // Address error store: BadVAddr capture
        bus.vaddr_M = 32'h0000_2FFE;
        drive(0, 5'd8, 32'h0, 5'd5, 32'h3060, 0, 6'h0, 0);
        #1 check("ades_req", {31'b0, bus.req}, 32'h1);
        tick();
`ifdef CP0_BADVADDR_EN
        bva_exp = 32'h0000_2FFE;
`else
        bva_exp = 32'h0;
`endif
        rd(5'd8, bva_exp, "badvaddr");
        rd(5'd13, 32'h0000_0014, "ades_cause");
        rd(5'd14, 32'h0000_3060, "ades_epc");
        drive(0, 5'd12, 32'h0, 5'd0, 32'h3060, 0, 6'h0, 1);
        tick();

        // Read-only / unimplemented indices ignore writes
        drive(1, 5'd13, 32'hFFFF_FFFF, 5'd0, 32'h3060, 0, 6'h0, 0);
        tick();
        rd(5'd13, 32'h0000_0014, "cause_ro");
        drive(1, 5'd15, 32'h0, 5'd0, 32'h3060, 0, 6'h0, 0);
        tick();
        rd(5'd15, 32'h0000_2021, "prid_ro");
        drive(1, 5'd8, 32'h1234_5678, 5'd0, 32'h3060, 0, 6'h0, 0);
        tick();
        rd(5'd8, bva_exp, "badvaddr_ro");

        // Reset beats exception, mtc0 and eret in the same cycle
        drive(1, 5'd12, 32'h0000_FC03, 5'd12, 32'h3070, 1, 6'h3F, 1);
        rst = 1'b1;
        #1 check("rstprio_req_before", {31'b0, bus.req}, 32'h1);
        tick();
        rst = 1'b0;
        rd(5'd12, 32'h0, "rstprio_sr");
        rd(5'd13, 32'h0, "rstprio_cause");
        rd(5'd14, 32'h0, "rstprio_epc");
        check("rstprio_req", {31'b0, bus.req}, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.A         = idx_tbl[$urandom_range(5)];
            bus.we        = ($urandom_range(3) == 0);
            bus.din       = $urandom;
            bus.excCode_M = exc_tbl[$urandom_range(6)];
            bus.pc_M      = $urandom;
            bus.bd_M      = $urandom_range(1);
            bus.HWInt     = ($urandom_range(2) == 0) ? 6'($urandom) : 6'h0;
            bus.EXLClr    = ($urandom_range(5) == 0);
            bus.vaddr_M   = $urandom;
            rst           = ($urandom_range(40) == 0);
            #1;
            check("rnd_req", {31'b0, bus.req}, {31'b0, m_req()});
            check("rnd_dout", bus.dout, m_read(bus.A));
            @(posedge clk);
            #1;
            check("rnd_epc", bus.EPC, m_epc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
